wb_scoreboard: RTL

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard for a four-slot VLIW issue stage
module wb_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bundle_valid,
  output logic                   bundle_ready,
  input  logic [4:0]             lsu_rs1,
  input  logic [4:0]             lsu_rs2,
  input  logic [4:0]             ixu1_rs1,
  input  logic [4:0]             ixu1_rs2,
  input  logic [4:0]             ixu2_rs1,
  input  logic [4:0]             ixu2_rs2,
  input  logic [4:0]             branch_rs1,
  input  logic [4:0]             branch_rs2,
  input  logic [4:0]             lsu_rd,
  input  logic [4:0]             ixu1_rd,
  input  logic [4:0]             ixu2_rd,
  input  logic [4:0]             branch_rd,
  input  logic                   lsu_rd_we,
  input  logic                   ixu1_rd_we,
  input  logic                   ixu2_rd_we,
  input  logic                   branch_rd_we,
  input  logic                   lsu_wb_en,
  input  logic                   ixu1_wb_en,
  input  logic                   ixu2_wb_en,
  input  logic                   branch_wb_en,
  input  logic [4:0]             lsu_wb_rd,
  input  logic [4:0]             ixu1_wb_rd,
  input  logic [4:0]             ixu2_wb_rd,
  input  logic [4:0]             branch_wb_rd,
  output logic [31:0]            pending_mask,
  output logic                   dest_conflict_err,
  output logic                   spurious_wb_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Slot order throughout: 0=lsu, 1=ixu1, 2=ixu2, 3=branch.
  logic [4:0] rs1   [4];
  logic [4:0] rs2   [4];
  logic [4:0] rd    [4];
  logic [4:0] wb_rd [4];
  logic [3:0] rd_we;
  logic [3:0] wb_en;

  assign rs1[0] = lsu_rs1;
  assign rs1[1] = ixu1_rs1;
  assign rs1[2] = ixu2_rs1;
  assign rs1[3] = branch_rs1;
  assign rs2[0] = lsu_rs2;
  assign rs2[1] = ixu1_rs2;
  assign rs2[2] = ixu2_rs2;
  assign rs2[3] = branch_rs2;
  assign rd[0]  = lsu_rd;
  assign rd[1]  = ixu1_rd;
  assign rd[2]  = ixu2_rd;
  assign rd[3]  = branch_rd;
  assign wb_rd[0] = lsu_wb_rd;
  assign wb_rd[1] = ixu1_wb_rd;
  assign wb_rd[2] = ixu2_wb_rd;
  assign wb_rd[3] = branch_wb_rd;
  assign rd_we = {branch_rd_we, ixu2_rd_we, ixu1_rd_we, lsu_rd_we};
  assign wb_en = {branch_wb_en, ixu2_wb_en, ixu1_wb_en, lsu_wb_en};

  logic        src_hazard;
  logic        dst_hazard;
  logic        intra_conflict;
  logic        issue;
  logic        spurious;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Hazard detection looks only at the registered mask; writebacks in flight are not bypassed.
  always_comb begin
    src_hazard     = 1'b0;
    dst_hazard     = 1'b0;
    intra_conflict = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rs1[i] != 5'd0 && pending_mask[rs1[i]]) src_hazard = 1'b1;
      if (rs2[i] != 5'd0 && pending_mask[rs2[i]]) src_hazard = 1'b1;
      if (rd_we[i] && rd[i] != 5'd0) begin
        if (pending_mask[rd[i]]) dst_hazard = 1'b1;
        for (int j = i + 1; j < 4; j++) begin
          if (rd_we[j] && rd[j] == rd[i]) intra_conflict = 1'b1;
        end
      end
    end
    // Fields of an absent bundle carry no meaning.
    if (!bundle_valid) begin
      src_hazard     = 1'b0;
      dst_hazard     = 1'b0;
      intra_conflict = 1'b0;
    end
  end

  assign bundle_ready = ~(src_hazard | dst_hazard | intra_conflict);
  assign issue        = bundle_valid & bundle_ready;

  // Build per-cycle set and clear masks plus the spurious-writeback indication.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (issue && rd_we[i] && rd[i] != 5'd0) set_mask[rd[i]] = 1'b1;
      if (wb_en[i] && wb_rd[i] != 5'd0) begin
        clr_mask[wb_rd[i]] = 1'b1;
        if (!pending_mask[wb_rd[i]]) spurious = 1'b1;
      end
    end
  end

  // Pending state, sticky errors and the saturating stall counter; set wins over clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_mask      <= 32'd0;
      dest_conflict_err <= 1'b0;
      spurious_wb_err   <= 1'b0;
      stall_count       <= '0;
    end else begin
      pending_mask <= ((pending_mask & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      if (bundle_valid && intra_conflict) dest_conflict_err <= 1'b1;
      if (spurious) spurious_wb_err <= 1'b1;
      if (bundle_valid && !bundle_ready && stall_count != {STALL_CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
